// File: rtl/memory_stage_if.sv
// Bundles the execute-side, data-bus and writeback handshakes of the memory stage.
// The stage drives requests and results through the master modport. The environment uses the slave modport.
interface memory_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu;
  logic [31:0] ex_sdata;
  logic [3:0]  ex_memop;
  logic [4:0]  ex_dst;
  logic        ex_regwr;

  logic        dreq_valid;
  logic        dreq_ready;
  logic [31:0] dreq_addr;
  logic [3:0]  dreq_strb;
  logic [31:0] dreq_wdata;
  logic        dresp_valid;
  logic [31:0] dresp_data;

  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_dst;
  logic        wb_regwr;
  logic        wb_exc;

  modport master (
    input  ex_valid, ex_alu, ex_sdata, ex_memop, ex_dst, ex_regwr,
    output ex_ready,
    output dreq_valid, dreq_addr, dreq_strb, dreq_wdata,
    input  dreq_ready, dresp_valid, dresp_data,
    output wb_valid, wb_data, wb_dst, wb_regwr, wb_exc,
    input  wb_ready
  );

  modport slave (
    output ex_valid, ex_alu, ex_sdata, ex_memop, ex_dst, ex_regwr,
    input  ex_ready,
    input  dreq_valid, dreq_addr, dreq_strb, dreq_wdata,
    output dreq_ready, dresp_valid, dresp_data,
    input  wb_valid, wb_data, wb_dst, wb_regwr, wb_exc,
    output wb_ready
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage. It issues at most one data-bus access at a time and formats load data.
// Results are held in a single-entry writeback register.
module memory_stage #(
  parameter int ALIGN_CHECK = 1
) (
  input  logic           clk,
  input  logic           reset,
  memory_stage_if.master bus
);
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        accept, is_mem, misaligned, launch, regwr_eff;
  logic [3:0]  strb_nxt;
  logic [31:0] wdata_nxt;
  logic [3:0]  p_op;
  logic [31:0] p_alu;
  logic [4:0]  p_dst;
  logic        p_regwr, p_store;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_data;
  logic        wb_load, wb_regwr_nxt, wb_exc_nxt;
  logic [31:0] wb_data_nxt;
  logic [4:0]  wb_dst_nxt;

  assign bus.ex_ready   = (state == IDLE) && (!bus.wb_valid || bus.wb_ready);
  assign accept         = bus.ex_valid && bus.ex_ready;
  assign is_mem         = bus.ex_memop inside {[OP_LB:OP_SW]};
  assign regwr_eff      = bus.ex_regwr && (bus.ex_dst != 5'd0);
  assign launch         = accept && is_mem && !misaligned;
  assign bus.dreq_valid = (state == REQ);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin : decode
    misaligned = 1'b0;
    strb_nxt   = 4'b0000;
    wdata_nxt  = bus.ex_sdata;
    case (bus.ex_memop)
      OP_LH, OP_LHU: misaligned = bus.ex_alu[0];
      OP_LW:         misaligned = |bus.ex_alu[1:0];
      OP_SB: begin
        strb_nxt  = 4'b0001 << bus.ex_alu[1:0];
        wdata_nxt = {4{bus.ex_sdata[7:0]}};
      end
      OP_SH: begin
        misaligned = bus.ex_alu[0];
        strb_nxt   = 4'b0011 << bus.ex_alu[1:0];
        wdata_nxt  = {2{bus.ex_sdata[15:0]}};
      end
      OP_SW: begin
        misaligned = |bus.ex_alu[1:0];
        strb_nxt   = 4'b1111;
      end
      default: ;
    endcase
    if (ALIGN_CHECK == 0) misaligned = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A response arriving together with the request handshake is ignored, because it is only seen in WAIT.
  always_comb begin : fsm_next
    state_nxt = state;
    unique case (state)
      IDLE:    if (launch)          state_nxt = REQ;
      REQ:     if (bus.dreq_ready)  state_nxt = WAIT;
      WAIT:    if (bus.dresp_valid) state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_comb begin : load_format
    case (p_alu[1:0])
      2'd0:    rbyte = bus.dresp_data[7:0];
      2'd1:    rbyte = bus.dresp_data[15:8];
      2'd2:    rbyte = bus.dresp_data[23:16];
      default: rbyte = bus.dresp_data[31:24];
    endcase
    rhalf = p_alu[1] ? bus.dresp_data[31:16] : bus.dresp_data[15:0];
    case (p_op)
      OP_LB:   load_data = {{24{rbyte[7]}}, rbyte};
      OP_LBU:  load_data = {24'd0, rbyte};
      OP_LH:   load_data = {{16{rhalf[15]}}, rhalf};
      OP_LHU:  load_data = {16'd0, rhalf};
      default: load_data = bus.dresp_data;
    endcase
  end

  always_comb begin : wb_next
    wb_load      = 1'b0;
    wb_data_nxt  = bus.ex_alu;
    wb_dst_nxt   = bus.ex_dst;
    wb_regwr_nxt = regwr_eff && !misaligned;
    wb_exc_nxt   = misaligned;
    if (accept && !launch) begin
      wb_load = 1'b1;
    end else if (state == WAIT && bus.dresp_valid) begin
      wb_load      = 1'b1;
      wb_data_nxt  = p_store ? p_alu : load_data;
      wb_dst_nxt   = p_dst;
      wb_regwr_nxt = p_regwr;
      wb_exc_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.wb_valid <= 1'b0;
      bus.wb_data  <= '0;
      bus.wb_dst   <= '0;
      bus.wb_regwr <= 1'b0;
      bus.wb_exc   <= 1'b0;
    end else if (wb_load) begin
      bus.wb_valid <= 1'b1;
      bus.wb_data  <= wb_data_nxt;
      bus.wb_dst   <= wb_dst_nxt;
      bus.wb_regwr <= wb_regwr_nxt;
      bus.wb_exc   <= wb_exc_nxt;
    end else if (bus.wb_valid && bus.wb_ready) begin
      bus.wb_valid <= 1'b0;
    end
  end

  // Request fields and the pending-op context are captured once, when the access is launched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.dreq_addr  <= '0;
      bus.dreq_strb  <= '0;
      bus.dreq_wdata <= '0;
      p_op           <= '0;
      p_alu          <= '0;
      p_dst          <= '0;
      p_regwr        <= 1'b0;
      p_store        <= 1'b0;
    end else if (launch) begin
      bus.dreq_addr  <= {bus.ex_alu[31:2], 2'b00};
      bus.dreq_strb  <= strb_nxt;
      bus.dreq_wdata <= wdata_nxt;
      p_op           <= bus.ex_memop;
      p_alu          <= bus.ex_alu;
      p_dst          <= bus.ex_dst;
      p_store        <= (strb_nxt != 4'b0000);
      p_regwr        <= regwr_eff && (strb_nxt == 4'b0000);
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage. A transaction-level model predicts each bus request and writeback.
// Literal checks pin the key cases.
module tb_memory_stage;
  localparam logic [3:0] NONE = 4'd0, LB = 4'd1, LBU = 4'd2, LH = 4'd3, LHU = 4'd4,
                         LW = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  dst;
    logic        regwr;
    logic        exc;
  } wb_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        has_wdata;
  } req_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  memory_stage_if bus();

  memory_stage #(.ALIGN_CHECK(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int req_cycles = 0;
  wb_t  exp_wb[$];
  req_t exp_req[$];
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_strb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr,
                                              input logic [31:0] word);
    int unsigned v;
    case (op)
      LB, LBU: begin
        v = (word >> (int'(addr[1:0]) * 8)) & 32'hFF;
        if (op == LB && v >= 128) v = v + 32'hFFFF_FF00;
      end
      LH, LHU: begin
        v = (word >> (int'(addr[1]) * 16)) & 32'hFFFF;
        if (op == LH && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic bit model_misaligned(input logic [3:0] op, input logic [31:0] addr);
    return ((op == LH || op == LHU || op == SH) && addr[0]) ||
           ((op == LW || op == SW) && addr[1:0] != 2'd0);
  endfunction

  // Presents one instruction, waits for acceptance and records what the stage must produce.
  task automatic issue(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] sdata,
                       input logic [4:0] dst, input logic regwr, input logic [31:0] rdata);
    bit ok, mem, mis;
    int lane;
    wb_t w;
    req_t r;
    @(posedge clk); #1;
    bus.ex_valid = 1'b1; bus.ex_memop = op; bus.ex_alu = alu;
    bus.ex_sdata = sdata; bus.ex_dst = dst; bus.ex_regwr = regwr;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = bus.ex_ready;
    end
    check("ex_accept", 32'(ok), 32'd1);
    if (ok) begin
      mem  = (op >= LB && op <= SW);
      mis  = model_misaligned(op, alu);
      lane = int'(alu[1:0]);
      w.dst = dst; w.exc = mis; w.data = alu; w.regwr = regwr && (dst != 5'd0);
      if (mis || (op >= SB && op <= SW)) w.regwr = 1'b0;
      else if (mem) w.data = model_load(op, alu, rdata);
      exp_wb.push_back(w);
      if (mem && !mis) begin
        r.addr = alu - 32'(lane);
        r.has_wdata = 1'b1;
        case (op)
          SB: begin r.strb = 4'(1 << lane); r.wdata = 32'h0101_0101 * {24'd0, sdata[7:0]}; end
          SH: begin r.strb = 4'(3 << lane); r.wdata = 32'h0001_0001 * {16'd0, sdata[15:0]}; end
          SW: begin r.strb = 4'hF; r.wdata = sdata; end
          default: begin r.strb = 4'h0; r.wdata = 32'd0; r.has_wdata = 1'b0; end
        endcase
        exp_req.push_back(r);
      end
    end
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;
  endtask

  // Plays the bus slave for an access already in REQ: stall, handshake, then answer.
  task automatic serve(input int ready_wait, input bit early, input int resp_wait,
                       input logic [31:0] rdata);
    repeat (ready_wait) begin @(posedge clk); #1; end
    bus.dreq_ready = 1'b1;
    if (early) begin bus.dresp_valid = 1'b1; bus.dresp_data = 32'hDEAD_BEEF; end
    @(posedge clk); #1;
    bus.dreq_ready = 1'b0; bus.dresp_valid = 1'b0;
    repeat (resp_wait) begin @(posedge clk); #1; end
    bus.dresp_valid = 1'b1; bus.dresp_data = rdata;
    @(posedge clk); #1;
    bus.dresp_valid = 1'b0; bus.dresp_data = 32'd0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_wb.size() != 0; i++) @(negedge clk);
    check("wb_drain", 32'(exp_wb.size()), 32'd0);
  endtask

  // Compare process: outputs against the model on every cycle they are valid.
  initial begin
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        exp_wb.delete();
        exp_req.delete();
      end else begin
        if (bus.dreq_valid === 1'b1) begin
          req_cycles++;
          seen_addr = bus.dreq_addr; seen_strb = bus.dreq_strb; seen_wdata = bus.dreq_wdata;
          if (exp_req.size() == 0) check("dreq_unexpected", 32'(bus.dreq_valid), 32'd0);
          else begin
            check("dreq_addr", bus.dreq_addr, exp_req[0].addr);
            check("dreq_strb", 32'(bus.dreq_strb), 32'(exp_req[0].strb));
            if (exp_req[0].has_wdata) check("dreq_wdata", bus.dreq_wdata, exp_req[0].wdata);
            if (bus.dreq_ready === 1'b1) void'(exp_req.pop_front());
          end
        end
        if (bus.wb_valid === 1'b1) begin
          if (exp_wb.size() == 0) check("wb_unexpected", 32'(bus.wb_valid), 32'd0);
          else begin
            check("wb_data", bus.wb_data, exp_wb[0].data);
            check("wb_dst", 32'(bus.wb_dst), 32'(exp_wb[0].dst));
            check("wb_regwr", 32'(bus.wb_regwr), 32'(exp_wb[0].regwr));
            check("wb_exc", 32'(bus.wb_exc), 32'(exp_wb[0].exc));
            if (bus.wb_ready === 1'b1) void'(exp_wb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ex_valid = 0; bus.ex_alu = 0; bus.ex_sdata = 0; bus.ex_memop = 0; bus.ex_dst = 0;
    bus.ex_regwr = 0; bus.dreq_ready = 0; bus.dresp_valid = 0; bus.dresp_data = 0;
    bus.wb_ready = 1;

    // Reset values
    #12;
    check("rst_dreq_valid", 32'(bus.dreq_valid), 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_wb_dst", 32'(bus.wb_dst), 32'd0);
    check("rst_wb_regwr", 32'(bus.wb_regwr), 32'd0);
    check("rst_wb_exc", 32'(bus.wb_exc), 32'd0);
    check("rst_dreq_strb", 32'(bus.dreq_strb), 32'd0);
    check("rst_dreq_addr", bus.dreq_addr, 32'd0);
    check("rst_dreq_wdata", bus.dreq_wdata, 32'd0);
    check("rst_ex_ready", 32'(bus.ex_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;

    // Pass-through ops
    issue(NONE, 32'h1234_5678, 32'd0, 5'd5, 1'b1, 32'd0);
    @(negedge clk);
    check("none_valid", 32'(bus.wb_valid), 32'd1);
    check("none_data", bus.wb_data, 32'h1234_5678);
    check("none_dst", 32'(bus.wb_dst), 32'd5);
    check("none_regwr", 32'(bus.wb_regwr), 32'd1);
    issue(NONE, 32'hA5A5_5A5A, 32'd0, 5'd0, 1'b1, 32'd0);
    @(negedge clk);
    check("dst0_regwr", 32'(bus.wb_regwr), 32'd0);
    issue(4'd12, 32'h0BAD_F00D, 32'd0, 5'd3, 1'b1, 32'd0);
    @(negedge clk);
    check("op12_data", bus.wb_data, 32'h0BAD_F00D);
    check("op12_no_req", 32'(bus.dreq_valid), 32'd0);

    // Byte loads from lane 3
    issue(LB, 32'h103, 32'd0, 5'd4, 1'b1, 32'h80FF_0000);
    serve(0, 0, 0, 32'h80FF_0000);
    @(negedge clk);
    check("lb_data", bus.wb_data, 32'hFFFF_FF80);
    check("lb_addr", seen_addr, 32'h100);
    check("lb_strb", 32'(seen_strb), 32'd0);
    issue(LBU, 32'h103, 32'd0, 5'd4, 1'b1, 32'h80FF_0000);
    serve(1, 0, 0, 32'h80FF_0000);
    @(negedge clk);
    check("lbu_data", bus.wb_data, 32'h0000_0080);

    // Halfword store with a stalled bus
    req_cycles = 0;
    issue(SH, 32'h202, 32'hAAAA_BEEF, 5'd9, 1'b1, 32'd0);
    serve(3, 0, 1, 32'd0);
    @(negedge clk);
    check("sh_req_cycles", 32'(req_cycles), 32'd4);
    check("sh_addr", seen_addr, 32'h200);
    check("sh_strb", 32'(seen_strb), 32'hC);
    check("sh_wdata", seen_wdata, 32'hBEEF_BEEF);
    check("sh_regwr", 32'(bus.wb_regwr), 32'd0);

    // Misaligned word load
    issue(LW, 32'h301, 32'd0, 5'd7, 1'b1, 32'd0);
    @(negedge clk);
    check("lw_mis_exc", 32'(bus.wb_exc), 32'd1);
    check("lw_mis_regwr", 32'(bus.wb_regwr), 32'd0);
    check("lw_mis_no_req", 32'(bus.dreq_valid), 32'd0);

    // Model-checked mix: every byte lane, halfword lanes, early response, more misaligned ops
    for (int l = 0; l < 4; l++) begin
      issue(SB, 32'h700 + 32'(l), 32'h1234_56C3, 5'd3, 1'b1, 32'd0);
      serve(l % 2, 0, l, 32'd0);
    end
    check("sb3_strb", 32'(seen_strb), 32'h8);
    check("sb3_wdata", seen_wdata, 32'hC3C3_C3C3);
    issue(LH, 32'h102, 32'd0, 5'd6, 1'b1, 32'h8001_7FFF);
    serve(0, 0, 0, 32'h8001_7FFF);
    @(negedge clk);
    check("lh_data", bus.wb_data, 32'hFFFF_8001);
    issue(LHU, 32'h100, 32'd0, 5'd6, 1'b1, 32'h8001_F00F);
    serve(2, 0, 1, 32'h8001_F00F);
    issue(LW, 32'h104, 32'd0, 5'd8, 1'b1, 32'h1357_9BDF);
    serve(0, 1, 2, 32'h1357_9BDF);
    @(negedge clk);
    check("lw_early_ignored", bus.wb_data, 32'h1357_9BDF);
    issue(SW, 32'h108, 32'hFEED_FACE, 5'd2, 1'b1, 32'd0);
    serve(1, 0, 0, 32'd0);
    issue(SH, 32'h205, 32'h1111_2222, 5'd1, 1'b1, 32'd0);
    issue(LHU, 32'h001, 32'd0, 5'd1, 1'b1, 32'd0);
    issue(SW, 32'h302, 32'h3333_4444, 5'd1, 1'b1, 32'd0);
    drain();

    // Writeback back-pressure
    @(posedge clk); #1;
    bus.wb_ready = 1'b0;
    issue(LW, 32'h400, 32'd0, 5'd12, 1'b1, 32'hCAFE_F00D);
    serve(0, 0, 2, 32'hCAFE_F00D);
    repeat (2) begin
      @(negedge clk);
      check("stall_ex_ready", 32'(bus.ex_ready), 32'd0);
      check("stall_wb_data", bus.wb_data, 32'hCAFE_F00D);
    end
    @(posedge clk); #1;
    bus.wb_ready = 1'b1;
    drain();

    // Reset while the request is pending
    issue(LW, 32'h500, 32'd0, 5'd2, 1'b1, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_req_dreq_valid", 32'(bus.dreq_valid), 32'd0);
    check("rst_req_ex_ready", 32'(bus.ex_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;

    // Reset in WAIT, then a late response
    issue(LW, 32'h600, 32'd0, 5'd2, 1'b1, 32'd0);
    bus.dreq_ready = 1'b1;
    @(posedge clk); #1;
    bus.dreq_ready = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_wait_dreq_valid", 32'(bus.dreq_valid), 32'd0);
    check("rst_wait_wb_valid", 32'(bus.wb_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    bus.dresp_valid = 1'b1; bus.dresp_data = 32'h1111_1111;
    @(posedge clk); #1;
    bus.dresp_valid = 1'b0; bus.dresp_data = 32'd0;
    repeat (3) begin
      @(negedge clk);
      check("late_resp_wb_valid", 32'(bus.wb_valid), 32'd0);
      check("late_resp_ex_ready", 32'(bus.ex_ready), 32'd1);
    end

    issue(NONE, 32'h77, 32'd0, 5'd1, 1'b1, 32'd0);
    drain();
    check("req_queue_empty", 32'(exp_req.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
